spmmio_serlink: RTL and testbench
=================================

# spmmio_serlink

Parametrised successor to the single-register TIPI serial bridge. Exchanges W-bit control/data frame pairs with an external peer over a clocked serial link, with parity, per-frame retry limiting and a receive FIFO so inbound pairs are not lost while the CPU is busy. It sits on the SP MMIO bus as a 4-word register window and drives the link pins directly.

## Interface
- W, 8, frame data width (8..16)
- DEPTH, 4, RX FIFO depth in pairs (power of 2, ≥2)
- CLKDIV, 8, clk cycles per tclk half-period (≥2)
- MAX_RETRY, 15, consecutive failed attempts before abandoning a frame (1..255)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- adr  in  4  word address within window
- cs, we  in  1  select / write strobe
- sel  in  4  byte lanes, sel[0] = d[0:7]
- d  in  32  write data, bit 0 = MSB
- q  out  32  read data, combinational on adr
- enable  in  1  link enable
- treset  in  1  peer reset level
- din  in  1  serial in
- tclk, rt, le, dout, dc  out  1  link clock, direction (1 = peer→us), frame start, serial out, control/data select (1 = control)

## Operation
- Register map (fields right-justified, W bits):
  - adr 0 read: q[0] enable, q[1] reset_changed, q[2] reset_level, q[3] err, q[4] fifo_nonempty, q[5] fifo_full, q[8:15] fifo_count.
  - adr 0 write, sel[0]: d[1]=1 and d[2]==reset_level → clear reset_changed; d[3]=1 → clear err.
  - adr 1: RC at q[0:15], RD at q[16:31]; write sel[1] loads RC from d[16-W:15], sel[3] loads RD from d[32-W:31].
  - adr 2 read: FIFO head TC at q[0:15], TD at q[16:31]; zero when empty. Write with sel[0] pops; pop on empty ignored.
  - Other addresses: q=0, writes ignored.
- treset ≠ reset_level (enable high) → reset_level<=treset, reset_changed<=1.
- Slot = clk edge where tick fires with tclk=1 (tclk then falls). All link state and outputs update only at slots; din sampled at the same edge.
- Receive (rt=1): le=1 slot → le<=0, clear shifter. Next W slots shift din in MSB first. Following slot is parity: din must equal XOR of the W bits.
  - Good, dc=1: hold<=bits, dc<=0, le<=1.
  - Good, dc=0, FIFO not full: push {hold,bits}, rt<=0, dc<=0, le<=1, retry<=0.
  - Good, dc=0, FIFO full: le<=1 (NAK), retry not incremented.
  - Bad parity: le<=1, retry++.
- Transmit (rt=0), frame = start slot (le<=0, dout<=0), W data slots (dout MSB first; RD when dc=0, RC when dc=1), parity slot (dout=XOR), ack slot (dout<=0, sample din).
  - Ack din=1: dc=0 → dc<=1, le<=1 (RC next); dc=1 → rt<=1, dc<=1, le<=1 (receive).
  - din=0: le<=1, resend same frame, retry++.
- retry reaching MAX_RETRY → err<=1 (sticky), retry<=0, rt<=1, dc<=1, le<=1.
- RC/RD writes mid-frame take effect at that frame's next attempt; the shifter is loaded at the start slot.
- enable low: link outputs to reset values, FIFO flushed, hold/retry cleared; err and registers kept; reset_changed<=0, reset_level<=0.

## Timing
- Reset values: tclk 0, rt 1, le 1, dout 0, dc 1, err 0, RC/RD 0, FIFO empty, reset_changed 0, reset_level 0.
- Divider counts 0..CLKDIV-1; tclk toggles on wrap. One slot per 2·CLKDIV clks.
- RX frame W+2 slots, TX frame W+3 slots; register write visible on q next cycle.
- FIFO push at parity slot edge, visible on q the next cycle. Simultaneous push and pop both apply, count unchanged. Pointers wrap mod DEPTH.
- Async reset mid-frame: all state to reset values immediately; no partial push.

## Test plan
- Reset, enable=1, W=8: peer sends ctrl 0x5A, par 0 / data 0xC3, par 0 → FIFO count 1, adr2 q=0x005A00C3; link turns to TX.
- RD=0x81, RC=0x7E, peer acks both → dout stream 0,10000001,0,ack then 0,01111110,0,ack; rt returns 1, dc 1.
- Bad parity on data frame 3 times then good → single push; retry cleared.
- DEPTH=4: fill 4 pairs, fifth data frame NAKed repeatedly without err; pop on same edge as retry push → count stays 4, new pair accepted.
- Peer never acks, MAX_RETRY=3 → err=1 after 3rd NAK, rt=1; write adr0 d[3]=1 clears err.
- Toggle treset → q[1]=1, q[2]=1; write d[1]=1,d[2]=0 leaves flag; d[2]=1 clears it.

Source files
------------

// File: rtl/spmmio_serlink_if.sv
// rtl/spmmio_serlink_if.sv - SP MMIO register-window bus between CPU side and the serial link bridge
// Bus bit 31 is the MSB-first bit 0; sel[k] selects the k-th byte counted from the MSB end.
interface spmmio_serlink_if;
    logic [3:0]  adr;
    logic        cs;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] d;
    logic [31:0] q;

    modport master (output adr, cs, we, sel, d, input q);
    modport slave  (input adr, cs, we, sel, d, output q);
endinterface

// File: rtl/spmmio_serlink.sv
// rtl/spmmio_serlink.sv - serial control/data frame-pair link with parity, retry limit and RX FIFO
// Link state only advances on slots: the clk edge where the divider wraps while tclk is high.
module spmmio_serlink #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int CLKDIV    = 8,
    parameter int MAX_RETRY = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    spmmio_serlink_if.slave  bus,
    input  logic             enable,
    input  logic             treset,
    input  logic             din,
    output logic             tclk,
    output logic             rt,
    output logic             le,
    output logic             dout,
    output logic             dc
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {PH_START, PH_BITS, PH_PAR, PH_ACK} phase_t;

    logic [CW-1:0]  div_q;
    logic           tclk_q, rt_q, le_q, dout_q, dc_q, par_q;
    phase_t         ph_q;
    logic [4:0]     bit_q;
    logic [W-1:0]   sh_q, hold_q, rc_q, rd_q, tx_word;
    logic [7:0]     retry_q;
    logic           err_q, rchg_q, rlvl_q;
    logic [2*W-1:0] mem_q [DEPTH];
    logic [PW-1:0]  wp_q, rp_q;
    logic [NW-1:0]  cnt_q;

    logic wr, tick, slot, full, pop, push, rx_par_ok, fail, give_up;
    logic unused_bits;

    assign wr        = bus.cs && bus.we;
    assign tick      = enable && (div_q == CW'(CLKDIV - 1));
    assign slot      = tick && tclk_q;
    assign full      = (cnt_q == NW'(DEPTH));
    assign pop       = wr && (bus.adr == 4'd2) && bus.sel[0] && (cnt_q != '0);
    assign rx_par_ok = (din == ^sh_q);
    // A pop on the parity edge frees a slot, so a full FIFO can still take the pair.
    assign push      = slot && rt_q && (ph_q == PH_PAR) && rx_par_ok && !dc_q && (!full || pop);
    assign fail      = slot && ((rt_q && (ph_q == PH_PAR) && !rx_par_ok) ||
                                (!rt_q && (ph_q == PH_ACK) && !din));
    assign give_up   = fail && (retry_q + 8'd1 == 8'(MAX_RETRY));
    assign tx_word   = dc_q ? rc_q : rd_q;
    assign unused_bits = ^{bus.sel[2], bus.d};

    assign tclk = tclk_q;
    assign rt   = rt_q;
    assign le   = le_q;
    assign dout = dout_q;
    assign dc   = dc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0; tclk_q <= 1'b0; rt_q <= 1'b1; le_q <= 1'b1; dout_q <= 1'b0;
            dc_q <= 1'b1; par_q <= 1'b0; ph_q <= PH_START; bit_q <= '0;
            sh_q <= '0; hold_q <= '0; retry_q <= '0;
        end else if (!enable) begin
            div_q <= '0; tclk_q <= 1'b0; rt_q <= 1'b1; le_q <= 1'b1; dout_q <= 1'b0;
            dc_q <= 1'b1; par_q <= 1'b0; ph_q <= PH_START; bit_q <= '0;
            sh_q <= '0; hold_q <= '0; retry_q <= '0;
        end else begin
            if (tick) begin
                div_q  <= '0;
                tclk_q <= !tclk_q;
            end else begin
                div_q <= div_q + CW'(1);
            end
            if (slot) begin
                if (give_up) begin
                    retry_q <= '0; rt_q <= 1'b1; dc_q <= 1'b1; le_q <= 1'b1;
                    dout_q <= 1'b0; ph_q <= PH_START;
                end else begin
                    case (ph_q)
                        PH_START: begin
                            le_q  <= 1'b0;
                            bit_q <= '0;
                            ph_q  <= PH_BITS;
                            if (rt_q) begin
                                sh_q <= '0;
                            end else begin
                                // RC/RD are sampled here, so mid-frame writes hit the next attempt.
                                sh_q   <= tx_word;
                                par_q  <= ^tx_word;
                                dout_q <= 1'b0;
                            end
                        end
                        PH_BITS: begin
                            if (rt_q) begin
                                sh_q <= {sh_q[W-2:0], din};
                            end else begin
                                dout_q <= sh_q[W-1];
                                sh_q   <= {sh_q[W-2:0], 1'b0};
                            end
                            bit_q <= bit_q + 5'd1;
                            if (bit_q == 5'(W - 1)) ph_q <= PH_PAR;
                        end
                        PH_PAR: begin
                            if (rt_q) begin
                                le_q <= 1'b1;
                                ph_q <= PH_START;
                                if (!rx_par_ok) begin
                                    retry_q <= retry_q + 8'd1;
                                end else if (dc_q) begin
                                    hold_q  <= sh_q;
                                    dc_q    <= 1'b0;
                                    retry_q <= '0;
                                end else if (push) begin
                                    rt_q    <= 1'b0;
                                    dc_q    <= 1'b0;
                                    retry_q <= '0;
                                end
                            end else begin
                                dout_q <= par_q;
                                ph_q   <= PH_ACK;
                            end
                        end
                        PH_ACK: begin
                            dout_q <= 1'b0;
                            le_q   <= 1'b1;
                            ph_q   <= PH_START;
                            if (din) begin
                                retry_q <= '0;
                                dc_q    <= 1'b1;
                                if (dc_q) rt_q <= 1'b1;
                            end else begin
                                retry_q <= retry_q + 8'd1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rc_q <= '0; rd_q <= '0; err_q <= 1'b0; rchg_q <= 1'b0; rlvl_q <= 1'b0;
        end else begin
            if (wr && (bus.adr == 4'd1)) begin
                if (bus.sel[1]) rc_q <= bus.d[16 +: W];
                if (bus.sel[3]) rd_q <= bus.d[W-1:0];
            end
            if (give_up) begin
                err_q <= 1'b1;
            end else if (wr && (bus.adr == 4'd0) && bus.sel[0] && bus.d[28]) begin
                err_q <= 1'b0;
            end
            if (!enable) begin
                rchg_q <= 1'b0;
                rlvl_q <= 1'b0;
            end else if (treset != rlvl_q) begin
                rlvl_q <= treset;
                rchg_q <= 1'b1;
            end else if (wr && (bus.adr == 4'd0) && bus.sel[0] && bus.d[30] &&
                         (bus.d[29] == rlvl_q)) begin
                rchg_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q <= '0; rp_q <= '0; cnt_q <= '0;
        end else if (!enable) begin
            wp_q <= '0; rp_q <= '0; cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + PW'(1);
            if (pop)  rp_q <= rp_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + NW'(1);
            else if (pop && !push) cnt_q <= cnt_q - NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= {hold_q, sh_q};
    end

    always_comb begin
        bus.q = '0;
        case (bus.adr)
            4'd0: begin
                bus.q[31]    = enable;
                bus.q[30]    = rchg_q;
                bus.q[29]    = rlvl_q;
                bus.q[28]    = err_q;
                bus.q[27]    = (cnt_q != '0);
                bus.q[26]    = full;
                bus.q[23:16] = 8'(cnt_q);
            end
            4'd1: begin
                bus.q[16 +: W] = rc_q;
                bus.q[W-1:0]   = rd_q;
            end
            4'd2: begin
                if (cnt_q != '0) begin
                    bus.q[16 +: W] = mem_q[rp_q][2*W-1:W];
                    bus.q[W-1:0]   = mem_q[rp_q][W-1:0];
                end
            end
            default: bus.q = '0;
        endcase
    end
endmodule

// File: tb/tb_spmmio_serlink.sv
// tb/tb_spmmio_serlink.sv - directed self-checking bench for spmmio_serlink with a bit-level peer
module tb_spmmio_serlink;
    localparam int W         = 8;
    localparam int DEPTH     = 4;
    localparam int CLKDIV    = 2;
    localparam int MAX_RETRY = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic treset = 1'b0;
    logic din = 1'b0;
    logic tclk, rt, le, dout, dc;
    int   checks = 0;
    int   errors = 0;

    spmmio_serlink_if bus();

    spmmio_serlink #(.W(W), .DEPTH(DEPTH), .CLKDIV(CLKDIV), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .enable(enable), .treset(treset),
        .din(din), .tclk(tclk), .rt(rt), .le(le), .dout(dout), .dc(dc)
    );

    always #5 clk = ~clk;

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] data, input logic [3:0] s);
        bus.adr = a; bus.d = data; bus.sel = s; bus.cs = 1'b1; bus.we = 1'b1;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.sel = 4'b0000;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
        bus.adr = a; bus.cs = 1'b1; bus.we = 1'b0;
        #1;
        v = bus.q;
        bus.cs = 1'b0;
    endtask

    // Drive din for the next slot and return just after that slot edge.
    task automatic slot(input logic b);
        logic p;
        din = b;
        for (int n = 0; n < 64; n++) begin
            p = tclk;
            @(posedge clk); #1;
            if (p && !tclk) return;
        end
        checks++; errors++;
        $display("FAIL slot_timeout got no tclk fall want fall within 64 clks");
    endtask

    task automatic rx_frame(input logic [W-1:0] v, input logic p);
        slot(1'b0);
        for (int i = W - 1; i >= 0; i--) slot(v[i]);
        slot(p);
    endtask

    task automatic tx_frame(input logic ack, output logic [W-1:0] v, output logic p, output logic st);
        slot(1'b0);
        st = (dout === 1'b0) && (le === 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            slot(1'b0);
            v[i] = dout;
        end
        slot(1'b0);
        p = dout;
        slot(ack);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        checks++; if ({tclk, rt, le, dout, dc} !== 5'b01101) begin errors++;
            $display("FAIL reset_pins got %b want 01101", {tclk, rt, le, dout, dc}); end
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h0000_0000) begin errors++;
            $display("FAIL reset_status got %h want 00000000", v); end
        bus_rd(4'd1, v);
        checks++; if (v !== 32'h0000_0000) begin errors++;
            $display("FAIL reset_rcrd got %h want 00000000", v); end
        bus_rd(4'd2, v);
        checks++; if (v !== 32'h0000_0000) begin errors++;
            $display("FAIL reset_head got %h want 00000000", v); end
    endtask

    task automatic test_rx_pair();
        logic [31:0] v;
        enable = 1'b1;
        rx_frame(8'h5A, 1'b0);
        checks++; if ({rt, le, dc} !== 3'b110) begin errors++;
            $display("FAIL rx_ctrl_state got %b want 110", {rt, le, dc}); end
        rx_frame(8'hC3, 1'b0);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8801_0000) begin errors++;
            $display("FAIL rx_status got %h want 88010000", v); end
        bus_rd(4'd2, v);
        checks++; if (v !== 32'h005A_00C3) begin errors++;
            $display("FAIL rx_head got %h want 005a00c3", v); end
        checks++; if ({rt, le, dc} !== 3'b010) begin errors++;
            $display("FAIL rx_turn got %b want 010", {rt, le, dc}); end
        bus_wr(4'd2, 32'h0, 4'b0001);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8000_0000) begin errors++;
            $display("FAIL pop_status got %h want 80000000", v); end
        bus_wr(4'd1, 32'h007E_0081, 4'b1010);
        bus_rd(4'd1, v);
        checks++; if (v !== 32'h007E_0081) begin errors++;
            $display("FAIL rcrd_write got %h want 007e0081", v); end
    endtask

    task automatic test_tx_pair();
        logic [W-1:0] v;
        logic p, st;
        tx_frame(1'b1, v, p, st);
        checks++; if ({st, v, p} !== {1'b1, 8'h81, 1'b0}) begin errors++;
            $display("FAIL tx_rd got start %b bits %h par %b want 1 81 0", st, v, p); end
        checks++; if ({rt, le, dc} !== 3'b011) begin errors++;
            $display("FAIL tx_rd_ack got %b want 011", {rt, le, dc}); end
        tx_frame(1'b1, v, p, st);
        checks++; if ({st, v, p} !== {1'b1, 8'h7E, 1'b0}) begin errors++;
            $display("FAIL tx_rc got start %b bits %h par %b want 1 7e 0", st, v, p); end
        checks++; if ({rt, le, dc} !== 3'b111) begin errors++;
            $display("FAIL tx_rc_ack got %b want 111", {rt, le, dc}); end
    endtask

    task automatic test_bad_parity();
        logic [31:0] v;
        rx_frame(8'h11, 1'b0);
        for (int i = 0; i < 3; i++) rx_frame(8'h07, 1'b0);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8000_0000 || {rt, dc} !== 2'b10) begin errors++;
            $display("FAIL badpar_hold got %h rt,dc %b want 80000000 10", v, {rt, dc}); end
        rx_frame(8'h07, 1'b1);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8801_0000) begin errors++;
            $display("FAIL badpar_status got %h want 88010000", v); end
        bus_rd(4'd2, v);
        checks++; if (v !== 32'h0011_0007) begin errors++;
            $display("FAIL badpar_head got %h want 00110007", v); end
    endtask

    task automatic test_retry_limit();
        logic [31:0] v;
        logic [W-1:0] b;
        logic p, st;
        for (int i = 0; i < 3; i++) begin
            tx_frame(1'b0, b, p, st);
            checks++; if ({st, b, p} !== {1'b1, 8'h81, 1'b0}) begin errors++;
                $display("FAIL nak_resend%0d got %b %h %b want 1 81 0", i, st, b, p); end
        end
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8801_0000 || rt !== 1'b0) begin errors++;
            $display("FAIL nak3_status got %h rt %b want 88010000 0", v, rt); end
        tx_frame(1'b0, b, p, st);
        checks++; if ({rt, le, dc} !== 3'b111) begin errors++;
            $display("FAIL giveup_state got %b want 111", {rt, le, dc}); end
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h9801_0000) begin errors++;
            $display("FAIL giveup_err got %h want 98010000", v); end
        bus_wr(4'd0, 32'h1000_0000, 4'b0001);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8801_0000) begin errors++;
            $display("FAIL err_clear got %h want 88010000", v); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] v;
        logic [W-1:0] c, b;
        logic p, st;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h0000_0000) begin errors++;
            $display("FAIL disable_status got %h want 00000000", v); end
        bus_rd(4'd1, v);
        checks++; if (v !== 32'h007E_0081) begin errors++;
            $display("FAIL disable_regs got %h want 007e0081", v); end
        enable = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            c = 8'h10 + 8'(i);
            rx_frame(c, ^c);
            c = 8'h20 + 8'(i);
            rx_frame(c, ^c);
            tx_frame(1'b1, b, p, st);
            tx_frame(1'b1, b, p, st);
        end
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8C04_0000) begin errors++;
            $display("FAIL full_status got %h want 8c040000", v); end
        rx_frame(8'h33, 1'b0);
        for (int i = 0; i < 5; i++) rx_frame(8'h44, 1'b0);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8C04_0000 || {rt, le, dc} !== 3'b110) begin errors++;
            $display("FAIL full_nak got %h %b want 8c040000 110", v, {rt, le, dc}); end
        c = 8'h44;
        slot(1'b0);
        for (int i = W - 1; i >= 0; i--) slot(c[i]);
        din = 1'b0;
        for (int n = 0; n < 64 && !tclk; n++) begin @(posedge clk); #1; end
        repeat (CLKDIV - 1) @(posedge clk);
        #1;
        bus.adr = 4'd2; bus.sel = 4'b0001; bus.cs = 1'b1; bus.we = 1'b1;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.sel = 4'b0000;
        checks++; if ({tclk, rt, le} !== 3'b001) begin errors++;
            $display("FAIL pop_push_edge got %b want 001", {tclk, rt, le}); end
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8C04_0000) begin errors++;
            $display("FAIL pop_push_count got %h want 8c040000", v); end
        bus_rd(4'd2, v);
        checks++; if (v !== 32'h0011_0021) begin errors++;
            $display("FAIL pop_push_head got %h want 00110021", v); end
        for (int i = 0; i < 3; i++) bus_wr(4'd2, 32'h0, 4'b0001);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8801_0000) begin errors++;
            $display("FAIL drain_status got %h want 88010000", v); end
        bus_rd(4'd2, v);
        checks++; if (v !== 32'h0033_0044) begin errors++;
            $display("FAIL drain_head got %h want 00330044", v); end
        enable = 1'b0;
    endtask

    task automatic test_treset();
        logic [31:0] v;
        repeat (2) @(posedge clk);
        #1;
        enable = 1'b1;
        treset = 1'b1;
        @(posedge clk); #1;
        bus_rd(4'd0, v);
        checks++; if (v !== 32'hE000_0000) begin errors++;
            $display("FAIL treset_set got %h want e0000000", v); end
        bus_wr(4'd0, 32'h4000_0000, 4'b0001);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'hE000_0000) begin errors++;
            $display("FAIL treset_wrong_level got %h want e0000000", v); end
        bus_wr(4'd0, 32'h6000_0000, 4'b0001);
        bus_rd(4'd0, v);
        checks++; if (v !== 32'hA000_0000) begin errors++;
            $display("FAIL treset_clear got %h want a0000000", v); end
        treset = 1'b0;
        @(posedge clk); #1;
        bus_rd(4'd0, v);
        checks++; if (v !== 32'hC000_0000) begin errors++;
            $display("FAIL treset_fall got %h want c0000000", v); end
        enable = 1'b0;
        @(posedge clk); #1;
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h0000_0000) begin errors++;
            $display("FAIL treset_disable got %h want 00000000", v); end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        enable = 1'b1;
        slot(1'b0);
        slot(1'b1);
        slot(1'b0);
        checks++; if (le !== 1'b0) begin errors++;
            $display("FAIL midframe_le got %b want 0", le); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if ({tclk, rt, le, dout, dc} !== 5'b01101) begin errors++;
            $display("FAIL async_pins got %b want 01101", {tclk, rt, le, dout, dc}); end
        bus_rd(4'd0, v);
        checks++; if (v !== 32'h8000_0000) begin errors++;
            $display("FAIL async_status got %h want 80000000", v); end
        bus_rd(4'd1, v);
        checks++; if (v !== 32'h0000_0000) begin errors++;
            $display("FAIL async_regs got %h want 00000000", v); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        enable = 1'b0;
    endtask

    initial begin
        bus.adr = 4'd0; bus.cs = 1'b0; bus.we = 1'b0; bus.sel = 4'b0000; bus.d = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset_n = 1'b1;
        @(posedge clk); #1;
        test_rx_pair();
        test_tx_pair();
        test_bad_parity();
        test_retry_limit();
        test_fifo_full();
        test_treset();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
